ex_result_skid: RTL and testbench

- Registered execute-to-writeback stage placed directly downstream of the 32-bit logic/ALU units (NOR, AND, OR, add, etc.).
- Captures the selected ALU result together with destination-register info, and derives zero/negative flags at capture.
- Presents the result to writeback through a valid/ready handshake.
- A 2-entry skid buffer lets the upstream ready be registered and still sustain full throughput.

---
 rtl/ex_result_skid.sv | 162 ++++++++++++++++
 tb/tb_ex_result_skid.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_skid.sv
// ex_result_skid: registered execute-to-writeback stage with a 2-entry skid buffer.
// Captures the ALU result, destination index and write enable, derives zero/negative
// flags at capture, and presents them through a valid/ready handshake with a
// registered in_ready.
// Optional feature: define EX_RESULT_PARITY_EN to add the out_parity output.
module ex_result_skid #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_W        = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic [RD_W-1:0]        in_rd,
  input  logic                   in_wen,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic [RD_W-1:0]        out_rd,
  output logic                   out_wen,
  output logic                   out_zero,
  output logic                   out_neg,
`ifdef EX_RESULT_PARITY_EN
  output logic                   out_parity,
`endif
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic              zero;
    logic              neg;
`ifdef EX_RESULT_PARITY_EN
    logic              parity;
`endif
  } entry_t;

  // Occupancy states: EMPTY (no entries), FULL1 (M only), FULL2 (M and S)
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL1 = 2'd1;
  localparam logic [1:0] ST_FULL2 = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  entry_t     m_q;
  entry_t     s_q;
  entry_t     in_entry;
  logic       accept;
  logic       retire;
  logic       load_m;
  logic       load_s;
  logic       move_s;

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  // Build the entry to be captured, deriving flags from the incoming result
  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.rd     = in_rd;
    in_entry.wen    = in_wen && (in_rd != '0);
    in_entry.zero   = (in_result == '0);
    in_entry.neg    = in_result[DATA_W-1];
`ifdef EX_RESULT_PARITY_EN
    in_entry.parity = ^in_result;
`endif
  end

  // Next occupancy state and entry load controls; flush overrides everything
  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_m  = 1'b1;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (accept && retire) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = ST_FULL2;
        end else if (retire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (retire) begin
          move_s  = 1'b1;
          state_d = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      load_m  = 1'b0;
      load_s  = 1'b0;
      move_s  = 1'b0;
    end
  end

  // State register with registered handshake flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_FULL2);
    end
  end

  // Entry storage: M takes new data or the skid entry, S takes overflow data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m) begin
        m_q <= in_entry;
      end else if (move_s) begin
        m_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_entry;
      end
    end
  end

  // Saturating count of back-pressured cycles, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_result = m_q.result;
  assign out_rd     = m_q.rd;
  assign out_wen    = m_q.wen;
  assign out_zero   = m_q.zero;
  assign out_neg    = m_q.neg;
`ifdef EX_RESULT_PARITY_EN
  assign out_parity = m_q.parity;
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Scoreboard bench for ex_result_skid: accepted inputs are queued with their
// raw fields, and every retired output is checked against the queue head.
module tb_ex_result_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_zero;
  logic        out_neg;
`ifdef EX_RESULT_PARITY_EN
  logic        out_parity;
`endif
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
  } sb_item_t;

  sb_item_t    sb[$];
  sb_item_t    head;
  int          checks   = 0;
  int          failures = 0;
  int          retired  = 0;
  int          base;
  logic [15:0] stall_model = 16'd0;

  ex_result_skid dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
`ifdef EX_RESULT_PARITY_EN
    .out_parity (out_parity),
`endif
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor on the falling edge: inputs and outputs are stable for the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          head = sb.pop_front();
          retired++;
          check_eq("sb_result", 64'(out_result), 64'(head.result));
          check_eq("sb_rd",     64'(out_rd),     64'(head.rd));
          check_eq("sb_wen",    64'(out_wen),    64'(head.wen && (head.rd != 5'd0)));
          check_eq("sb_zero",   64'(out_zero),   64'(head.result == 32'd0));
          check_eq("sb_neg",    64'(out_neg),    64'(head.result[31]));
`ifdef EX_RESULT_PARITY_EN
          check_eq("sb_parity", 64'(out_parity), 64'(^head.result));
`endif
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back('{result: in_result, rd: in_rd, wen: in_wen});
      end
      if (out_valid && !out_ready && (stall_model != 16'hFFFF)) begin
        stall_model = stall_model + 16'd1;
      end
    end
  end

  // Present one item and hold it until accepted; call and return at posedge+1
  task automatic send(input logic [31:0] r, input logic [4:0] rd, input logic w);
    bit   ok;
    logic seen;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_result = r;
    in_rd     = rd;
    in_wen    = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
      if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) until the scoreboard and the stage are both empty
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cycles(1);
    end
    check_eq("drain_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_result = 32'd0;
    in_rd     = 5'd0;
    in_wen    = 1'b0;
    out_ready = 1'b0;
    cycles(2);

    // Reset values
    check_eq("rst_out_valid",  64'(out_valid),  64'd0);
    check_eq("rst_in_ready",   64'(in_ready),   64'd1);
    check_eq("rst_out_result", 64'(out_result), 64'd0);
    check_eq("rst_out_rd",     64'(out_rd),     64'd0);
    check_eq("rst_out_flags",  64'({out_wen, out_zero, out_neg}), 64'd0);
    check_eq("rst_stall_cnt",  64'(stall_cnt),  64'd0);
`ifdef EX_RESULT_PARITY_EN
    check_eq("rst_out_parity", 64'(out_parity), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single transfer: one-cycle latency and flag derivation
    out_ready = 1'b1;
    send(32'hFFFF0000, 5'd3, 1'b1);
    check_eq("t1_out_valid",  64'(out_valid),  64'd1);
    check_eq("t1_out_result", 64'(out_result), 64'hFFFF0000);
    check_eq("t1_out_rd",     64'(out_rd),     64'd3);
    check_eq("t1_out_wen",    64'(out_wen),    64'd1);
    check_eq("t1_out_neg",    64'(out_neg),    64'd1);
    check_eq("t1_out_zero",   64'(out_zero),   64'd0);
    // Zero result to r0: zero flag set, write enable suppressed
    send(32'h00000000, 5'd0, 1'b1);
    check_eq("t2_out_zero",   64'(out_zero),   64'd1);
    check_eq("t2_out_wen",    64'(out_wen),    64'd0);
    check_eq("t2_out_neg",    64'(out_neg),    64'd0);
    drain();

    // Stream 1..8 with back-pressure, fill the skid entry, then release
    base      = retired;
    out_ready = 1'b0;
    send(32'd1, 5'd1, 1'b1);
    check_eq("s_full1_in_ready", 64'(in_ready), 64'd1);
    send(32'd2, 5'd2, 1'b1);
    check_eq("s_full2_in_ready", 64'(in_ready), 64'd0);
    check_eq("s_full2_head",     64'(out_result), 64'd1);
    cycles(5);
    check_eq("s_hold_head",      64'(out_result), 64'd1);
    check_eq("s_stall_cnt",      64'(stall_cnt),  64'd6);
    check_eq("s_stall_model",    64'(stall_cnt),  64'(stall_model));
    out_ready = 1'b1;
    for (int i = 3; i <= 8; i++) begin
      send(32'(i), 5'(i), 1'b1);
    end
    drain();
    check_eq("s_retired", 64'(retired - base), 64'd8);
    check_eq("s_stall_after", 64'(stall_cnt), 64'(stall_model));

    // Flush while FULL2 with a pending input: nothing survives
    out_ready = 1'b0;
    send(32'hAAAA0001, 5'd4, 1'b1);
    send(32'hAAAA0002, 5'd5, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'hAAAA0003;
    in_rd     = 5'd6;
    in_wen    = 1'b1;
    flush     = 1'b1;
    cycles(1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    check_eq("f2_out_valid", 64'(out_valid), 64'd0);
    check_eq("f2_in_ready",  64'(in_ready),  64'd1);

    // Flush while FULL1 with an acceptable input: the accept is dropped
    send(32'hBBBB0001, 5'd7, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'hBBBB0002;
    in_rd     = 5'd8;
    flush     = 1'b1;
    cycles(1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    check_eq("f1_out_valid", 64'(out_valid), 64'd0);
    check_eq("f1_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    cycles(4);
    check_eq("f_no_output",  64'(out_valid), 64'd0);
    check_eq("f_stall_cnt",  64'(stall_cnt), 64'(stall_model));

    // Long stall: counter saturates and holds
    out_ready = 1'b0;
    send(32'h12345678, 5'd9, 1'b1);
    cycles(70000);
    check_eq("sat_stall_cnt",  64'(stall_cnt), 64'hFFFF);
    cycles(3);
    check_eq("sat_stall_hold", 64'(stall_cnt), 64'hFFFF);
    check_eq("sat_model",      64'(stall_cnt), 64'(stall_model));
    check_eq("sat_head",       64'(out_result), 64'h12345678);
    out_ready = 1'b1;
    drain();

`ifdef EX_RESULT_PARITY_EN
    // Parity of captured result
    out_ready = 1'b1;
    send(32'h00000007, 5'd1, 1'b1);
    check_eq("par_odd",  64'(out_parity), 64'd1);
    send(32'h00000003, 5'd1, 1'b1);
    check_eq("par_even", 64'(out_parity), 64'd0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
